// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the two-requester APB master.
//   - FSM state encoding for apb_master_arbiter
//   - response error codes and slave-select codes
//   - APB address/data widths
// No ports (package).
package apb_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_SLV     = 2'd1,
    ERR_SEL     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_GPIO = 2'd1,
    SEL_UART = 2'd2,
    SEL_BAD  = 2'd3
  } sel_e;

  function automatic logic sel_is_valid(logic [1:0] sel);
    return (sel == SEL_GPIO) || (sel == SEL_UART);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: two-way round-robin grant for the APB master.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   valid0_i/1_i     request pending from requester 0/1
//   accept_i         a grant was taken this cycle (updates history)
//   gnt0_o/gnt1_o    combinational one-hot (or zero) grant
module apb_rr_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic accept_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // Index of the requester that won most recently; reset to 1 so that
  // requester 0 wins the first tie.
  logic last_grant_q;

  always_comb begin
    gnt0_o = valid0_i && (!valid1_i || last_grant_q);
    gnt1_o = valid1_i && !gnt0_o;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (accept_i) begin
      last_grant_q <= gnt1_o;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB bus between two command sources and
// runs each transfer through SETUP/ACCESS to GPIO (sel 1) or UART (sel 2).
// One response pulse is returned per accepted request.
//
// state  | meaning
// IDLE   | arbitrate, accept one request
// SETUP  | psel high, penable low
// ACCESS | psel+penable high, wait for selected pready
// RESP   | one-cycle response pulse, bus released
//
// Ports: pclk/reset (sync, active high); req0_*/req1_* request channels
// (valid/ready/write/sel/addr/wdata); rsp_* response pulse; APB master side
// psel1/psel2/penable/pwrite/paddr/pwdata with per-slave pready/prdata and
// a shared pslverr; busy = not IDLE.
// Optional feature macro: APB_ARB_TIMEOUT_EN aborts ACCESS after
// TIMEOUT_CYCLES cycles of pready low (rsp_err = 3).
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [1:0]        req0_sel,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [1:0]        req1_sel,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              psel1,
  output logic              psel2,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready1,
  input  logic              pready2,
  input  logic [DATA_W-1:0] prdata1,
  input  logic [DATA_W-1:0] prdata2,
  input  logic              pslverr,
  output logic              busy
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e              state_q, state_d;
  logic                id_q, id_d;
  logic                write_q, write_d;
  logic [1:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  err_e                err_q, err_d;
  logic                gnt0, gnt1, accept;
  logic                sel_pready;
  logic [DATA_W-1:0]   sel_prdata;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  apb_rr_arbiter u_arb (
    .clk      (pclk),
    .reset    (reset),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .accept_i (accept),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1)
  );

  // Only the latched target's handshake is ever looked at.
  assign sel_pready = (sel_q == SEL_GPIO) ? pready1 : pready2;
  assign sel_prdata = (sel_q == SEL_GPIO) ? prdata1 : prdata2;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    write_d = write_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          accept  = 1'b1;
          id_d    = gnt1;
          write_d = gnt1 ? req1_write : req0_write;
          sel_d   = gnt1 ? req1_sel   : req0_sel;
          addr_d  = gnt1 ? req1_addr  : req0_addr;
          wdata_d = gnt1 ? req1_wdata : req0_wdata;
          rdata_d = '0;
          if (sel_is_valid(sel_d)) begin
            err_d   = ERR_OK;
            state_d = ST_SETUP;
          end else begin
            err_d   = ERR_SEL;
            state_d = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_pready) begin
          err_d   = pslverr ? ERR_SLV : ERR_OK;
          // Read data is only returned for clean reads.
          rdata_d = (!write_q && !pslverr) ? sel_prdata : '0;
          state_d = ST_RESP;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      id_q    <= 1'b0;
      write_q <= 1'b0;
      sel_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Ready is masked during reset so nothing appears accepted at that edge.
  assign req0_ready = (state_q == ST_IDLE) && !reset && gnt0;
  assign req1_ready = (state_q == ST_IDLE) && !reset && gnt1;

  assign psel1   = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) && (sel_q == SEL_GPIO);
  assign psel2   = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) && (sel_q == SEL_UART);
  assign penable = (state_q == ST_ACCESS);
  assign pwrite  = write_q;
  assign paddr   = addr_q;
  assign pwdata  = wdata_q;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_valid ? id_q : 1'b0;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid ? err_q : ERR_OK;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

  logic        pclk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_write;
  logic [1:0]  req0_sel;
  logic [4:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [1:0]  req1_sel;
  logic [4:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        psel1, psel2, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic        pready1, pready2;
  logic [31:0] prdata1, prdata2;
  logic        pslverr;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int rsp_seen = 0;
  int rsp_mark;

  apb_master_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_sel(req0_sel), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_sel(req1_sel), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel1(psel1), .psel2(psel2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .pready1(pready1), .pready2(pready2), .prdata1(prdata1), .prdata2(prdata2),
    .pslverr(pslverr), .busy(busy)
  );

  always #5 pclk = ~pclk;

  // Each RESP state lasts exactly one cycle, so one sample per cycle counts responses.
  always @(negedge pclk) if (rsp_valid === 1'b1) rsp_seen <= rsp_seen + 1;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus_idle(input string tag);
    check({tag, ".psel1"},   {31'd0, psel1},   32'd0);
    check({tag, ".psel2"},   {31'd0, psel2},   32'd0);
    check({tag, ".penable"}, {31'd0, penable}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_write = 0; req0_sel = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_sel = 0; req1_addr = 0; req1_wdata = 0;
    pready1 = 1'b1; pready2 = 1'b0; prdata1 = 32'h5555_5555; prdata2 = 32'h0;
    pslverr = 1'b0;
    tick(); tick();

    // Reset state
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_bus_idle("rst");
    check("rst.paddr", {27'd0, paddr}, 32'd0);
    check("rst.pwdata", pwdata, 32'd0);
    check("rst.pwrite", {31'd0, pwrite}, 32'd0);
    reset = 1'b0;
    tick();

    // 1) req0 write GPIO, zero-wait slave
    req0_valid = 1; req0_write = 1; req0_sel = 2'd1; req0_addr = 5'h04; req0_wdata = 32'hDEADBEEF;
    #1;
    check("t1.ready0", {31'd0, req0_ready}, 32'd1);
    check("t1.ready1", {31'd0, req1_ready}, 32'd0);
    tick();                                   // SETUP
    req0_valid = 0; req0_wdata = 32'h0; req0_addr = 5'h1F;
    check("t1.setup.psel1", {31'd0, psel1}, 32'd1);
    check("t1.setup.penable", {31'd0, penable}, 32'd0);
    check("t1.setup.paddr", {27'd0, paddr}, 32'h04);
    check("t1.setup.pwdata", pwdata, 32'hDEADBEEF);
    check("t1.setup.pwrite", {31'd0, pwrite}, 32'd1);
    check("t1.setup.ready0", {31'd0, req0_ready}, 32'd0);
    tick();                                   // ACCESS
    check("t1.access.psel1", {31'd0, psel1}, 32'd1);
    check("t1.access.penable", {31'd0, penable}, 32'd1);
    check("t1.access.pwdata", pwdata, 32'hDEADBEEF);
    tick();                                   // RESP
    check("t1.resp.valid", {31'd0, rsp_valid}, 32'd1);
    check("t1.resp.id", {31'd0, rsp_id}, 32'd0);
    check("t1.resp.err", {30'd0, rsp_err}, 32'd0);
    check("t1.resp.rdata", rsp_rdata, 32'd0);
    check_bus_idle("t1.resp");
    tick();                                   // IDLE
    check("t1.idle.busy", {31'd0, busy}, 32'd0);
    check("t1.idle.rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // 2) req1 read UART, three wait states; GPIO pready/prdata must be ignored
    req1_valid = 1; req1_write = 0; req1_sel = 2'd2; req1_addr = 5'h02;
    pready2 = 0; prdata2 = 32'h0000_00A5;
    #1;
    check("t2.ready1", {31'd0, req1_ready}, 32'd1);
    tick();                                   // SETUP (T+1)
    req1_valid = 0;
    check("t2.setup.psel2", {31'd0, psel2}, 32'd1);
    check("t2.setup.psel1", {31'd0, psel1}, 32'd0);
    check("t2.setup.paddr", {27'd0, paddr}, 32'h02);
    for (int i = 0; i < 3; i++) begin
      tick();                                 // ACCESS, waiting (T+2..T+4)
      check("t2.wait.penable", {31'd0, penable}, 32'd1);
      check("t2.wait.psel1", {31'd0, psel1}, 32'd0);
      check("t2.wait.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    tick();                                   // ACCESS (T+5), slave ready
    pready2 = 1;
    tick();                                   // RESP (T+6)
    check("t2.resp.valid", {31'd0, rsp_valid}, 32'd1);
    check("t2.resp.id", {31'd0, rsp_id}, 32'd1);
    check("t2.resp.rdata", rsp_rdata, 32'h0000_00A5);
    check("t2.resp.err", {30'd0, rsp_err}, 32'd0);
    tick();

    // 3) Both requesters continuously valid after reset: grants alternate 0,1,...
    reset = 1; tick(); reset = 0;
    pready1 = 1; pready2 = 1; prdata1 = 32'h1111_0000; prdata2 = 32'h2222_0000;
    req0_valid = 1; req0_write = 0; req0_sel = 2'd1; req0_addr = 5'h01;
    req1_valid = 1; req1_write = 0; req1_sel = 2'd2; req1_addr = 5'h03;
    rsp_mark = rsp_seen;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t3.ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("t3.ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick(); tick(); tick();                 // SETUP, ACCESS, RESP
      check("t3.resp.valid", {31'd0, rsp_valid}, 32'd1);
      check("t3.resp.id", {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check("t3.resp.rdata", rsp_rdata, (i % 2 == 0) ? 32'h1111_0000 : 32'h2222_0000);
      tick();                                 // IDLE
    end
    req0_valid = 0; req1_valid = 0;
    tick();
    check("t3.resp_count", rsp_seen - rsp_mark, 32'd8);

    // 4) Invalid sel: no APB activity, error 2 one cycle after accept
    req0_valid = 1; req0_write = 1; req0_sel = 2'd3; req0_addr = 5'h07; req0_wdata = 32'h1234_5678;
    prdata1 = 32'hFFFF_FFFF; prdata2 = 32'hFFFF_FFFF;
    #1;
    check("t4.ready0", {31'd0, req0_ready}, 32'd1);
    tick();                                   // RESP (T+1)
    req0_valid = 0;
    check("t4.resp.valid", {31'd0, rsp_valid}, 32'd1);
    check("t4.resp.err", {30'd0, rsp_err}, 32'd2);
    check("t4.resp.rdata", rsp_rdata, 32'd0);
    check_bus_idle("t4.resp");
    tick();
    check("t4.idle.busy", {31'd0, busy}, 32'd0);
    check_bus_idle("t4.idle");

    // 4b) sel = 0 is likewise rejected
    req1_valid = 1; req1_write = 0; req1_sel = 2'd0;
    tick();
    req1_valid = 0;
    check("t4b.resp.err", {30'd0, rsp_err}, 32'd2);
    check("t4b.resp.id", {31'd0, rsp_id}, 32'd1);
    check_bus_idle("t4b.resp");
    tick();

    // 5) Slave error on GPIO write
    req0_valid = 1; req0_write = 1; req0_sel = 2'd1; req0_addr = 5'h08; req0_wdata = 32'hCAFE_F00D;
    pready1 = 1; pslverr = 1;
    tick();
    req0_valid = 0;
    tick(); tick();                           // ACCESS, RESP
    check("t5.resp.valid", {31'd0, rsp_valid}, 32'd1);
    check("t5.resp.err", {30'd0, rsp_err}, 32'd1);
    check("t5.resp.rdata", rsp_rdata, 32'd0);
    pslverr = 0;
    tick();

    // 6) Reset during ACCESS aborts silently
    req1_valid = 1; req1_write = 1; req1_sel = 2'd2; req1_addr = 5'h0A; req1_wdata = 32'hA5A5_A5A5;
    pready2 = 0;
    tick();                                   // SETUP
    req1_valid = 0;
    tick();                                   // ACCESS
    check("t6.access.penable", {31'd0, penable}, 32'd1);
    rsp_mark = rsp_seen;
    reset = 1;
    tick();
    check("t6.rst.busy", {31'd0, busy}, 32'd0);
    check_bus_idle("t6.rst");
    check("t6.rst.paddr", {27'd0, paddr}, 32'd0);
    check("t6.rst.pwdata", pwdata, 32'd0);
    check("t6.rst.pwrite", {31'd0, pwrite}, 32'd0);
    check("t6.rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 0;
    pready2 = 1;
    tick(); tick(); tick(); tick();
    check("t6.no_rsp", rsp_seen - rsp_mark, 32'd0);
    check("t6.idle.busy", {31'd0, busy}, 32'd0);

    // 7) ACCESS with pready held low
    req0_valid = 1; req0_write = 0; req0_sel = 2'd1; req0_addr = 5'h05;
    pready1 = 0;
    tick();                                   // SETUP
    req0_valid = 0;
    tick();                                   // ACCESS #1
    for (int i = 1; i < 16; i++) tick();      // ACCESS #16
    check("t7.access16.penable", {31'd0, penable}, 32'd1);
    tick();
`ifdef APB_ARB_TIMEOUT_EN
    check("t7.timeout.valid", {31'd0, rsp_valid}, 32'd1);
    check("t7.timeout.err", {30'd0, rsp_err}, 32'd3);
    check("t7.timeout.rdata", rsp_rdata, 32'd0);
    check_bus_idle("t7.timeout");
    tick();
    check("t7.idle.busy", {31'd0, busy}, 32'd0);
`else
    for (int i = 0; i < 8; i++) tick();
    check("t7.still_waiting.penable", {31'd0, penable}, 32'd1);
    check("t7.still_waiting.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    pready1 = 1; prdata1 = 32'h0000_0077;
    tick();
    check("t7.late.err", {30'd0, rsp_err}, 32'd0);
    check("t7.late.rdata", rsp_rdata, 32'h0000_0077);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master that shares the single APB bus between independent command sources (e.g. a CPU-side port and a test/DMA port) and sequences each transfer through the SETUP and ACCESS phases to the GPIO slave (sel 1) or the UART slave (sel 2). It arbitrates round-robin, drives one-hot slave selects, and muxes PREADY/PRDATA back from the selected slave. It returns one response per accepted request, carrying read data and an error code. It sits between the requesters and the GPIO/UART slave instances, in place of a testbench-driven bridge.

## Interface
- TIMEOUT_CYCLES, 16: ACCESS-phase wait limit, used only with APB_ARB_TIMEOUT_EN; must be ≥ 2.
- pclk  in  1  bus clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request pending.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_write / req1_write  in  1  1 = write, 0 = read.
- req0_sel / req1_sel  in  2  target: 0 = idle/invalid, 1 = GPIO, 2 = UART, 3 = invalid.
- req0_addr / req1_addr  in  5  register address.
- req0_wdata / req1_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester index of the response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  2  0 = OK, 1 = PSLVERR, 2 = bad sel, 3 = timeout.
- psel1 / psel2  out  1  GPIO / UART select.
- penable, pwrite  out  1  APB control.
- paddr  out  5, pwdata  out  32  APB address and data.
- pready1 / pready2  in  1; prdata1 / prdata2  in  32  per-slave returns.
- pslverr  in  1  slave error, sampled with the selected pready (tie 0 if unused).
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE, arbitration:
  - If any reqN_valid is high, grant one request. reqN_ready is combinational and high only for the winner.
  - The request is latched at the valid&&ready edge.
  - Round-robin: on a tie, grant the requester that did not win last. last_grant resets to 1, so req0 wins the first tie.
- Valid sel after accept → SETUP:
  - psel1 or psel2 = 1 per latched sel; penable = 0.
  - paddr, pwrite and pwdata driven from the latch and held stable through ACCESS.
- SETUP → ACCESS unconditionally: penable = 1.
- ACCESS, waiting for the selected pready:
  - Stay while it is 0.
  - On 1: capture the selected prdata (reads only) and pslverr, then go to RESP.
- RESP, one cycle:
  - psel*/penable = 0; rsp_valid = 1 with rsp_id, rsp_rdata and rsp_err (1 if pslverr was captured, else 0); then IDLE.
- Invalid sel (0 or 3) at accept:
  - No APB activity; go straight to RESP with rsp_err = 2 and rsp_rdata = 0.
- Non-selected slave's pready/prdata are ignored at all times.
- Only one transfer in flight. reqN_ready is never high outside IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, last_grant = 1, latches 0.
- Reset mid-transfer: bus signals drop at the reset edge and no response is emitted for the aborted request.
- Accept at edge T:
  - SETUP during T+1.
  - ACCESS from T+2.
  - With zero-wait pready, RESP during T+3 and IDLE at T+4, so the next accept is possible at T+4.
- Each wait cycle adds one cycle to this latency.
- Bad-sel request: RESP during T+1.
- Simultaneous valid on both requesters: exactly one ready; the loser keeps valid asserted and is served next.
- pwdata and paddr only change in IDLE.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - An ACCESS-phase counter counts cycles with pready low.
  - When it reaches TIMEOUT_CYCLES, the transfer is aborted: go to RESP with rsp_err = 3 and rsp_rdata = 0; psel/penable drop in RESP.
  - The counter clears on SETUP.
- APB_ARB_TIMEOUT_EN undefined:
  - ACCESS waits indefinitely.
  - Error code 3 is never produced and no counter logic is synthesized.

## Structure
- Shared package apb_pkg:
  - FSM state encoding.
  - Error codes (ERR_OK, ERR_SLV, ERR_SEL, ERR_TIMEOUT).
  - Slave-select constants (SEL_IDLE = 0, SEL_GPIO = 1, SEL_UART = 2).
  - Address and data width constants (5, 32).
- Sub-module apb_rr_arbiter: 2-way round-robin grant from valids and last_grant, combinational, plus the last_grant register.

## Test plan
- req0 write GPIO addr 5'h04 data 32'hDEADBEEF, pready1 tied 1:
  - psel1 high for 2 cycles, penable high in the 2nd.
  - rsp_valid at T+3 with rsp_id 0, rsp_err 0.
- req1 read UART addr 5'h02, pready2 high after 3 wait cycles, prdata2 = 32'h0000_00A5:
  - rsp_rdata = 32'hA5 at T+6.
  - psel1 never asserts.
- Both requesters valid continuously, 4 transfers each:
  - Grants alternate 0,1,0,1,…, starting with 0 after reset.
  - 8 responses, none lost.
- req0_sel = 3:
  - No psel/penable activity; rsp_err = 2 at T+1.
  - pslverr = 1 with pready1 on a GPIO write gives rsp_err = 1.
- Reset asserted during ACCESS:
  - Next edge all outputs are 0 and state is IDLE; no rsp_valid.
  - With APB_ARB_TIMEOUT_EN and pready held 0: rsp_err = 3 after 16 ACCESS cycles.
